// File: rtl/stepper_pkg.sv
// Shared types and default constants for the step/direction pulse generator.
// The ramp multiplier is only consumed when STEPPER_RAMP_EN is defined.
package stepper_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_DONE
    } state_e;

    localparam int DEF_CNT_W      = 16;
    localparam int DEF_PER_W      = 16;
    localparam int DEF_PULSE_W    = 4;
    localparam int DEF_SETUP_CYC  = 8;
    localparam int DEF_RAMP_DELTA = 16;
    localparam int RAMP_MULT      = 4;

endpackage

// File: rtl/stepper_interval_timer.sv
// Loadable down-counter: load N-1 on state entry, expire_o is high in the
// last cycle of an N-cycle interval.
module stepper_interval_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/stepper_step_gen.sv
// Command-driven step/direction pulse generator for the stepper driver.
// Define STEPPER_RAMP_EN to add a linear trapezoidal acceleration ramp.
module stepper_step_gen
    import stepper_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int PER_W     = DEF_PER_W,
    parameter int PULSE_W   = DEF_PULSE_W,
    parameter int SETUP_CYC = DEF_SETUP_CYC
`ifdef STEPPER_RAMP_EN
    ,
    parameter int RAMP_DELTA = DEF_RAMP_DELTA
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [PER_W-1:0] cmd_period,
    input  logic             cmd_dir,
    input  logic             abort,
    output logic             step,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] steps_left
);

    localparam logic [PER_W-1:0] MIN_PER  = PER_W'(PULSE_W + 1);
    localparam logic [PER_W-1:0] HIGH_LD  = PER_W'(PULSE_W - 1);
    localparam logic [PER_W-1:0] SETUP_LD = PER_W'(SETUP_CYC - 1);

    state_e             state_q, state_d;
    logic               dir_q, dir_d;
    logic               aborted_q, aborted_d;
    logic               abort_pend_q, abort_pend_d;
    logic [CNT_W-1:0]   steps_q, steps_d;
    logic [PER_W-1:0]   eff_q, eff_d;
    logic [PER_W-1:0]   eff_calc;
    logic [PER_W-1:0]   per_now;
    logic               accept;
    logic               rise_next;
    logic               tmr_load;
    logic [PER_W-1:0]   tmr_val;
    logic               tmr_exp;

    assign eff_calc = (cmd_period < MIN_PER) ? MIN_PER : cmd_period;

    stepper_interval_timer #(
        .W (PER_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (tmr_exp)
    );

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        aborted_d    = aborted_q;
        abort_pend_d = abort_pend_q;
        steps_d      = steps_q;
        eff_d        = eff_q;
        accept       = 1'b0;
        rise_next    = 1'b0;
        tmr_load     = 1'b0;
        tmr_val      = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept       = 1'b1;
                    dir_d        = cmd_dir;
                    steps_d      = cmd_steps;
                    eff_d        = eff_calc;
                    aborted_d    = 1'b0;
                    abort_pend_d = 1'b0;
                    if (cmd_steps == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = SETUP_LD;
                    end
                end
            end
            ST_SETUP: begin
                if (abort) begin
                    state_d   = ST_DONE;
                    aborted_d = 1'b1;
                end else if (tmr_exp) begin
                    state_d  = ST_HIGH;
                    steps_d  = steps_q - 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = HIGH_LD;
                end
            end
            ST_HIGH: begin
                // An abort seen anywhere in the pulse is remembered so the
                // high time is never truncated.
                if (abort) begin
                    abort_pend_d = 1'b1;
                end
                if (tmr_exp) begin
                    abort_pend_d = 1'b0;
                    if (abort || abort_pend_q) begin
                        state_d   = ST_DONE;
                        aborted_d = 1'b1;
                    end else begin
                        state_d  = ST_LOW;
                        tmr_load = 1'b1;
                        tmr_val  = per_now - MIN_PER;
                    end
                end
            end
            ST_LOW: begin
                if (abort) begin
                    state_d   = ST_DONE;
                    aborted_d = 1'b1;
                end else if (tmr_exp) begin
                    if (steps_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_HIGH;
                        rise_next = 1'b1;
                        steps_d   = steps_q - 1'b1;
                        tmr_load  = 1'b1;
                        tmr_val   = HIGH_LD;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            dir_q        <= 1'b0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            steps_q      <= '0;
            eff_q        <= MIN_PER;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            aborted_q    <= aborted_d;
            abort_pend_q <= abort_pend_d;
            steps_q      <= steps_d;
            eff_q        <= eff_d;
        end
    end

`ifdef STEPPER_RAMP_EN
    localparam int               WW       = PER_W + 3;
    localparam logic [WW-1:0]    PER_MAX  = WW'({PER_W{1'b1}});
    localparam logic [PER_W:0]   DELTA_W  = (PER_W + 1)'(RAMP_DELTA);

    logic [PER_W-1:0] ival_q, ival_d;
    logic [PER_W-1:0] start_q, start_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [WW-1:0]    start_wide;
    logic [PER_W-1:0] ramp_start;
    logic [PER_W:0]   grow_w;
    logic [PER_W:0]   floor_w;

    assign start_wide = WW'(eff_calc) * WW'(RAMP_MULT);
    assign ramp_start = (start_wide > PER_MAX) ? {PER_W{1'b1}} : start_wide[PER_W-1:0];
    assign grow_w     = {1'b0, ival_q} + DELTA_W;
    assign floor_w    = {1'b0, eff_q} + DELTA_W;

    // Intervals shrink until the floor, and grow back once the remaining
    // steps no longer exceed the number of accelerated steps taken.
    always_comb begin
        ival_d  = ival_q;
        start_d = start_q;
        acc_d   = acc_q;
        if (accept) begin
            ival_d  = ramp_start;
            start_d = ramp_start;
            acc_d   = '0;
        end else if (rise_next) begin
            if (steps_q <= acc_q) begin
                ival_d = (grow_w > {1'b0, start_q}) ? start_q : grow_w[PER_W-1:0];
            end else if (ival_q > eff_q) begin
                ival_d = ({1'b0, ival_q} > floor_w) ? (ival_q - DELTA_W[PER_W-1:0]) : eff_q;
                acc_d  = acc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ival_q  <= MIN_PER;
            start_q <= MIN_PER;
            acc_q   <= '0;
        end else begin
            ival_q  <= ival_d;
            start_q <= start_d;
            acc_q   <= acc_d;
        end
    end

    assign per_now = ival_q;
`else
    assign per_now = eff_q;
`endif

    assign step       = (state_q == ST_HIGH);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign cmd_ready  = (state_q == ST_IDLE);
    assign dir        = dir_q;
    assign aborted    = aborted_q;
    assign steps_left = steps_q;

endmodule
